hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS core; it generates the write-enables and bubble-select that the ID/EX register and the PC/IF-ID stage consume. It tracks the load currently in EX to detect load-use hazards, inserts single-cycle bubbles, flushes IF/ID on taken branches, and freezes the whole front end during data-memory misses. It sits beside the ID stage and is the sole driver of the ID/EX enable.

## Interface
- MEM_TIMEOUT, 64: max cycles in MEM_WAIT before forced release and error flag
- CNT_W, 16: width of stall cycle counter
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- id_rs_i  in  5  rs field of instruction in ID
- id_rt_i  in  5  rt field of instruction in ID
- id_uses_rt_i  in  1  instruction in ID reads rt as a source
- id_memread_i  in  1  instruction in ID is a load (MemRead control bit)
- branch_taken_i  in  1  branch resolved taken in ID this cycle
- mem_stall_req_i  in  1  data memory miss, pipeline must freeze
- mem_ready_i  in  1  data memory miss serviced
- pc_en_o  out  1  write enable for PC and IF/ID
- idex_en_o  out  1  write enable for ID/EX (its pcEnable input)
- bubble_o  out  1  selects zero WB/M/EX controls into ID/EX
- flush_if_o  out  1  clears IF/ID to a NOP
- stall_cnt_o  out  CNT_W  total stalled cycles, saturating
- err_o  out  1  sticky memory-timeout flag

## Operation
- States: RUN, MEM_WAIT. Reset state RUN.
- Shadow registers ex_memread_q, ex_rt_q mirror the load bit and rt of the instruction now in EX. Updated only when idex_en_o=1: loaded with (id_memread_i & ~bubble_o, id_rt_i). Held when idex_en_o=0.
- load_use = ex_memread_q & (ex_rt_q != 0) & ((ex_rt_q == id_rs_i) | (id_uses_rt_i & ex_rt_q == id_rt_i)).
- Output priority, evaluated combinationally each cycle:
  1. rst_i high: pc_en_o=0, idex_en_o=0, bubble_o=0, flush_if_o=0.
  2. Freeze (RUN with mem_stall_req_i=1, or MEM_WAIT with mem_ready_i=0 and timeout not reached): pc_en_o=0, idex_en_o=0, bubble_o=0, flush_if_o=0.
  3. load_use: pc_en_o=0, idex_en_o=1, bubble_o=1, flush_if_o=0. Branch taken in the same cycle is ignored; it is re-evaluated after the bubble.
  4. branch_taken_i: pc_en_o=1, idex_en_o=1, bubble_o=0, flush_if_o=1.
  5. Otherwise: pc_en_o=1, idex_en_o=1, others 0.
- Transitions: RUN→MEM_WAIT when mem_stall_req_i=1 and mem_ready_i=0. RUN stays RUN if both high (single-cycle freeze). MEM_WAIT→RUN when mem_ready_i=1, or when wait counter reaches MEM_TIMEOUT−1 (sets err_o).
- Wait counter: cleared on entry to MEM_WAIT, increments each MEM_WAIT cycle.
- stall_cnt_o increments on every cycle with pc_en_o=0 (freeze or load-use), saturates at all-ones.
- err_o clears only on reset.

## Timing
- Control outputs are combinational from state, shadow regs and inputs: same-cycle effect, zero latency.
- Reset values: state RUN, ex_memread_q=0, ex_rt_q=0, wait counter 0, stall_cnt_o=0, err_o=0.
- Load-use stall lasts exactly one cycle: the bubble clears ex_memread_q on the following edge.
- The release cycle of MEM_WAIT (mem_ready_i=1) is a normal cycle; load_use/branch rules apply in that cycle.
- Reset asserted mid-MEM_WAIT: immediate return to RUN, counters cleared, outputs forced per rule 1.
- Register $0 never causes a load-use stall.

## Test plan
- Load-use on rs: cycle N ID lw $5 (idex_en=1), N+1 ID add rs=5 → pc_en_o=0, bubble_o=1, idex_en_o=1 at N+1; N+2 pc_en_o=1, bubble_o=0; stall_cnt_o=1.
- Load to $0 followed by add rs=0, and load $5 followed by an instruction with rt=5 and id_uses_rt_i=0 → no stall.
- Miss: mem_stall_req_i pulse at N, mem_ready_i at N+3 → pc_en_o/idex_en_o=0 for N..N+2, 1 at N+3; stall_cnt_o=3; err_o=0.
- Timeout with MEM_TIMEOUT=4, mem_ready_i held 0 → freeze for 5 cycles total (entry cycle + 4 in MEM_WAIT), then RUN; err_o=1 until rst_i.
- Branch_taken_i with no hazard → flush_if_o=1, pc_en_o=1 same cycle. Branch_taken_i during load_use → flush_if_o=0, bubble_o=1.
- Async reset asserted mid-MEM_WAIT, between edges → outputs 0 immediately; after release, state RUN, stall_cnt_o=0, pc_en_o=1.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage MIPS core: load-use bubbles,
// taken-branch IF/ID flush and front-end freeze during data-memory misses.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             id_memread_i,
    input  logic             branch_taken_i,
    input  logic             mem_stall_req_i,
    input  logic             mem_ready_i,
    output logic             pc_en_o,
    output logic             idex_en_o,
    output logic             bubble_o,
    output logic             flush_if_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             err_o
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                ex_memread_q;
    logic [4:0]          ex_rt_q;
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic [CNT_W-1:0]    stall_cnt_q;
    logic                err_q;

    logic                load_use;
    logic                freeze;
    logic                timeout_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Hazard detection against the load currently sitting in EX
    always_comb begin
        load_use    = ex_memread_q && (ex_rt_q != 5'd0) &&
                      ((ex_rt_q == id_rs_i) || (id_uses_rt_i && (ex_rt_q == id_rt_i)));
        timeout_hit = (state_q == MEM_WAIT) && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));
        freeze      = (state_q == RUN) ? mem_stall_req_i : ~mem_ready_i;
    end

    always_comb begin
        pc_en_o    = 1'b0;
        idex_en_o  = 1'b0;
        bubble_o   = 1'b0;
        flush_if_o = 1'b0;
        state_d    = state_q;

        if (rst_i || freeze) begin
            pc_en_o   = 1'b0;
            idex_en_o = 1'b0;
        end else if (load_use) begin
            // a taken branch here is dropped; it resolves again after the bubble
            idex_en_o = 1'b1;
            bubble_o  = 1'b1;
        end else if (branch_taken_i) begin
            pc_en_o    = 1'b1;
            idex_en_o  = 1'b1;
            flush_if_o = 1'b1;
        end else begin
            pc_en_o   = 1'b1;
            idex_en_o = 1'b1;
        end

        case (state_q)
            RUN:      if (mem_stall_req_i && !mem_ready_i) state_d = MEM_WAIT;
            MEM_WAIT: if (mem_ready_i || timeout_hit)      state_d = RUN;
            default:                                       state_d = RUN;
        endcase
    end

    // State, EX shadow and counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= RUN;
            ex_memread_q <= 1'b0;
            ex_rt_q      <= 5'd0;
            wait_cnt_q   <= '0;
            stall_cnt_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (idex_en_o) begin
                ex_memread_q <= id_memread_i & ~bubble_o;
                ex_rt_q      <= id_rt_i;
            end
            wait_cnt_q <= (state_q == RUN) ? '0 : wait_cnt_q + 1'b1;
            if (!pc_en_o)
                stall_cnt_q <= sat_inc(stall_cnt_q);
            if (timeout_hit && !mem_ready_i)
                err_q <= 1'b1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: table-driven cycle vectors through a scoreboard queue,
// plus hand sequences for memory timeout and asynchronous reset mid-wait.
module tb_hazard_ctrl;

    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        ur;
        logic        mr;
        logic        br;
        logic        req;
        logic        rdy;
        logic [3:0]  ctl;   // {pc_en, idex_en, bubble, flush_if}
        logic [15:0] cnt;
        logic        err;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [4:0]  id_rs_i = '0;
    logic [4:0]  id_rt_i = '0;
    logic        id_uses_rt_i = 1'b0;
    logic        id_memread_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic        mem_stall_req_i = 1'b0;
    logic        mem_ready_i = 1'b0;
    logic        pc_en_o, idex_en_o, bubble_o, flush_if_o, err_o;
    logic [15:0] stall_cnt_o;

    int total = 0;
    int bad   = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i),
        .id_memread_i(id_memread_i), .branch_taken_i(branch_taken_i),
        .mem_stall_req_i(mem_stall_req_i), .mem_ready_i(mem_ready_i),
        .pc_en_o(pc_en_o), .idex_en_o(idex_en_o), .bubble_o(bubble_o),
        .flush_if_o(flush_if_o), .stall_cnt_o(stall_cnt_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                input logic ur, input logic mr, input logic br,
                                input logic req, input logic rdy,
                                input logic [3:0] ctl, input logic [15:0] cnt,
                                input logic err);
        vec_t v;
        v.rs = rs; v.rt = rt; v.ur = ur; v.mr = mr; v.br = br;
        v.req = req; v.rdy = rdy; v.ctl = ctl; v.cnt = cnt; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1: drive one cycle, compare at the following negedge.
    task automatic step(input vec_t v, input string tag);
        vec_t e;
        id_rs_i = v.rs; id_rt_i = v.rt; id_uses_rt_i = v.ur; id_memread_i = v.mr;
        branch_taken_i = v.br; mem_stall_req_i = v.req; mem_ready_i = v.rdy;
        exp_q.push_back(v);
        @(negedge clk_i);
        if (exp_q.size() == 0) begin
            chk({tag, " queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, " ctl"}, {28'd0, pc_en_o, idex_en_o, bubble_o, flush_if_o}, {28'd0, e.ctl});
            chk({tag, " stall_cnt"}, {16'd0, stall_cnt_o}, {16'd0, e.cnt});
            chk({tag, " err"}, {31'd0, err_o}, {31'd0, e.err});
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        //        rs  rt  ur mr br rq rd  ctl      cnt err
        tbl.push_back(mk(0,  0,  0, 0, 0, 0, 0, 4'b1100, 0, 0));  // nop
        tbl.push_back(mk(1,  5,  0, 1, 0, 0, 0, 4'b1100, 0, 0));  // lw $5
        tbl.push_back(mk(5,  6,  1, 0, 0, 0, 0, 4'b0110, 0, 0));  // add rs=5 -> bubble
        tbl.push_back(mk(5,  6,  1, 0, 0, 0, 0, 4'b1100, 1, 0));  // resumes
        tbl.push_back(mk(1,  0,  0, 1, 0, 0, 0, 4'b1100, 1, 0));  // lw $0
        tbl.push_back(mk(0,  0,  1, 0, 0, 0, 0, 4'b1100, 1, 0));  // $0 never stalls
        tbl.push_back(mk(2,  5,  0, 1, 0, 0, 0, 4'b1100, 1, 0));  // lw $5
        tbl.push_back(mk(3,  5,  0, 0, 0, 0, 0, 4'b1100, 1, 0));  // rt=5 not a source
        tbl.push_back(mk(2,  7,  0, 1, 0, 0, 0, 4'b1100, 1, 0));  // lw $7
        tbl.push_back(mk(1,  7,  1, 0, 0, 0, 0, 4'b0110, 1, 0));  // rt source hazard
        tbl.push_back(mk(1,  7,  1, 0, 0, 0, 0, 4'b1100, 2, 0));
        tbl.push_back(mk(1,  2,  0, 0, 1, 0, 0, 4'b1101, 2, 0));  // taken branch
        tbl.push_back(mk(1,  9,  0, 1, 0, 0, 0, 4'b1100, 2, 0));  // lw $9
        tbl.push_back(mk(9,  0,  0, 0, 1, 0, 0, 4'b0110, 2, 0));  // branch masked by bubble
        tbl.push_back(mk(9,  0,  0, 0, 1, 0, 0, 4'b1101, 3, 0));  // branch re-evaluated
        tbl.push_back(mk(0,  0,  0, 0, 0, 1, 0, 4'b0000, 3, 0));  // miss entry
        tbl.push_back(mk(0,  0,  0, 0, 0, 0, 0, 4'b0000, 4, 0));
        tbl.push_back(mk(0,  0,  0, 0, 0, 0, 0, 4'b0000, 5, 0));
        tbl.push_back(mk(0,  0,  0, 0, 0, 0, 1, 4'b1100, 6, 0));  // release
        tbl.push_back(mk(0,  0,  0, 0, 0, 1, 1, 4'b0000, 6, 0));  // single-cycle freeze
        tbl.push_back(mk(0,  0,  0, 0, 0, 0, 0, 4'b1100, 7, 0));
        tbl.push_back(mk(1,  4,  0, 1, 0, 0, 0, 4'b1100, 7, 0));  // lw $4
        tbl.push_back(mk(4,  0,  0, 0, 0, 1, 0, 4'b0000, 7, 0));  // freeze beats load-use
        tbl.push_back(mk(4,  0,  0, 0, 0, 0, 0, 4'b0000, 8, 0));
        tbl.push_back(mk(4,  0,  0, 0, 0, 0, 1, 4'b0110, 9, 0));  // load-use in release cycle
        tbl.push_back(mk(4,  0,  0, 0, 0, 0, 0, 4'b1100, 10, 0));

        // Reset state, with inputs that would otherwise assert outputs
        branch_taken_i = 1'b1;
        @(negedge clk_i);
        chk("reset ctl", {28'd0, pc_en_o, idex_en_o, bubble_o, flush_if_o}, 32'd0);
        chk("reset stall_cnt", {16'd0, stall_cnt_o}, 32'd0);
        chk("reset err", {31'd0, err_o}, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], $sformatf("vec%0d", i));

        // Timeout: entry cycle plus four MEM_WAIT cycles frozen, then RUN with err set
        step(mk(0, 0, 0, 0, 0, 1, 0, 4'b0000, 10, 0), "to_entry");
        for (int i = 0; i < 4; i++)
            step(mk(0, 0, 0, 0, 0, 0, 0, 4'b0000, 16'(11 + i), 0), $sformatf("to_wait%0d", i));
        step(mk(0, 0, 0, 0, 0, 0, 0, 4'b1100, 15, 1), "to_release");
        step(mk(0, 0, 0, 0, 0, 0, 0, 4'b1100, 15, 1), "to_sticky");

        // Asynchronous reset in the middle of a MEM_WAIT cycle
        step(mk(0, 0, 0, 0, 0, 1, 0, 4'b0000, 15, 1), "rst_entry");
        step(mk(0, 0, 0, 0, 0, 0, 0, 4'b0000, 16, 1), "rst_wait");
        mem_ready_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        chk("async rst ctl", {28'd0, pc_en_o, idex_en_o, bubble_o, flush_if_o}, 32'd0);
        chk("async rst stall_cnt", {16'd0, stall_cnt_o}, 32'd0);
        chk("async rst err", {31'd0, err_o}, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        step(mk(0, 0, 0, 0, 0, 0, 0, 4'b1100, 0, 0), "post_rst");
        step(mk(3, 4, 1, 0, 1, 0, 0, 4'b1101, 0, 0), "post_rst_br");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
